// File: rtl/vehicle_sensor_qualifier_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vehicle_sensor_qualifier_if                                     |
// | Brief    : Loop input, count clear and qualified-request outputs.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface vehicle_sensor_qualifier_if #(
  parameter int CNT_W = 8
);
  logic             loop_raw;
  logic             count_clr;
  logic             car_present;
  logic             car_pulse;
  logic [CNT_W-1:0] car_count;
  logic             sensor_fault;

  modport master (
    output loop_raw, count_clr,
    input  car_present, car_pulse, car_count, sensor_fault
  );

  modport slave (
    input  loop_raw, count_clr,
    output car_present, car_pulse, car_count, sensor_fault
  );
endinterface
`default_nettype wire

// File: rtl/vehicle_sensor_qualifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vehicle_sensor_qualifier                                        |
// | Brief    : Sync, debounce, gap-stretch and count the country-road loop;    |
// |            optional stuck-on detection enabled by STUCK_DETECT_EN.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vehicle_sensor_qualifier #(
  parameter int DEBOUNCE    = 4,
  parameter int HOLD        = 8,
  parameter int STUCK_LIMIT = 255,
  parameter int CNT_W       = 8
) (
  input wire                         clock,
  input wire                         clear,
  vehicle_sensor_qualifier_if.slave  bus
);
  localparam int c_MAX_DH = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
  localparam int c_CW     = $clog2(c_MAX_DH + 1);
  localparam logic [c_CW-1:0]  c_DEB_LAST  = c_CW'(DEBOUNCE - 1);
  localparam logic [c_CW-1:0]  c_HOLD_INIT = c_CW'(HOLD);
  localparam logic [c_CW-1:0]  c_ONE       = c_CW'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

  if (DEBOUNCE < 2 || HOLD < 1 || STUCK_LIMIT <= DEBOUNCE) begin : g_param_check
    $error("vehicle_sensor_qualifier: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARRIVE   = 3'd1,
    S_OCCUPIED = 3'd2,
    S_DEPART   = 3'd3,
    S_HOLD     = 3'd4
`ifdef STUCK_DETECT_EN
    , S_FAULT  = 3'd5
`endif
  } state_t;

  logic             r_s1;
  logic             r_loop_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_CW-1:0]  r_cnt;
  logic [c_CW-1:0]  w_cnt_nxt;
  logic             w_arrival;
  logic             r_car_present;
  logic             r_car_pulse;
  logic [CNT_W-1:0] r_car_count;

`ifdef STUCK_DETECT_EN
  localparam int c_SW = $clog2(STUCK_LIMIT + 1);
  localparam logic [c_SW-1:0] c_STUCK_LAST = c_SW'(STUCK_LIMIT - 1);

  logic [c_SW-1:0] r_stuck;
  logic            r_sensor_fault;
  logic            w_stuck_hit;

  // Hitting the limit on this edge moves the FSM to FAULT on the same edge.
  assign w_stuck_hit = (r_state == S_OCCUPIED) && r_loop_s && (r_stuck == c_STUCK_LAST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_stuck        <= '0;
      r_sensor_fault <= 1'b0;
    end else begin
      if (!r_loop_s)
        r_stuck <= '0;
      else if (r_state == S_OCCUPIED)
        r_stuck <= r_stuck + c_SW'(1);
      r_sensor_fault <= (w_state_nxt == S_FAULT);
    end
  end

  assign bus.sensor_fault = r_sensor_fault;
`else
  assign bus.sensor_fault = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_arrival   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_loop_s) begin
          w_state_nxt = S_ARRIVE;
          w_cnt_nxt   = c_ONE;
        end
      end
      S_ARRIVE: begin
        if (!r_loop_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DEB_LAST) begin
          w_state_nxt = S_OCCUPIED;
          w_cnt_nxt   = '0;
          w_arrival   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end
      S_OCCUPIED: begin
        if (!r_loop_s) begin
          w_state_nxt = S_DEPART;
          w_cnt_nxt   = c_ONE;
        end
`ifdef STUCK_DETECT_EN
        else if (w_stuck_hit) begin
          w_state_nxt = S_FAULT;
          w_cnt_nxt   = '0;
        end
`endif
      end
      S_DEPART: begin
        if (r_loop_s) begin
          w_state_nxt = S_OCCUPIED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DEB_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_HOLD_INIT;
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end
      S_HOLD: begin
        // A returning car during hold is the same occupancy: no new arrival.
        if (r_loop_s) begin
          w_state_nxt = S_OCCUPIED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_ONE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
`ifdef STUCK_DETECT_EN
      S_FAULT: begin
        if (r_loop_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_DEB_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_s1          <= 1'b0;
      r_loop_s      <= 1'b0;
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_car_present <= 1'b0;
      r_car_pulse   <= 1'b0;
      r_car_count   <= '0;
    end else begin
      r_s1          <= bus.loop_raw;
      r_loop_s      <= r_s1;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_car_present <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ARRIVE);
      r_car_pulse   <= w_arrival;
      if (bus.count_clr)
        r_car_count <= w_arrival ? CNT_W'(1) : '0;
      else if (w_arrival && (r_car_count != c_CNT_MAX))
        r_car_count <= r_car_count + CNT_W'(1);
    end
  end

  assign bus.car_present = r_car_present;
  assign bus.car_pulse   = r_car_pulse;
  assign bus.car_count   = r_car_count;

endmodule
`default_nettype wire

// File: doc/vehicle_sensor_qualifier.md
# vehicle_sensor_qualifier

Conditions the raw inductive-loop signal from the country-road vehicle detector into a clean, glitch-free car-present request. Its `car_present` output drives the `X` input of `traffic_light_controller` directly. The block synchronises the asynchronous loop, debounces both edges, stretches short gaps between vehicles, counts arrivals, and flags a stuck-on sensor.

## Interface
Parameters:
- `DEBOUNCE`, default 4: consecutive synchronised samples needed to accept a level change. Legal range ≥2.
- `HOLD`, default 8: cycles `car_present` stays high after a debounced departure. Legal range ≥1.
- `STUCK_LIMIT`, default 255: consecutive high samples before a sensor fault is declared. Must be greater than `DEBOUNCE`.
- `CNT_W`, default 8: width of `car_count`.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  system clock, rising-edge.
- `clear`  in  1  asynchronous active-high reset.
- `loop_raw`  in  1  raw loop detector, asynchronous to `clock`.
- `count_clr`  in  1  synchronous clear of `car_count`.
- `car_present`  out  1  qualified vehicle request; feeds the controller's `X` input.
- `car_pulse`  out  1  one-cycle strobe on each qualified arrival.
- `car_count`  out  `CNT_W`  saturating arrival count.
- `sensor_fault`  out  1  high while the loop is judged stuck-on.

## Operation
- **Synchroniser.** Two flops, `loop_raw` → `s1` → `loop_s`. All FSM decisions use `loop_s` only.
- **FSM states:** IDLE, ARRIVE, OCCUPIED, DEPART, HOLD, FAULT. One shared debounce/hold counter, sized `$clog2(max(DEBOUNCE,HOLD)+1)`.
- **IDLE** (`car_present`=0)
  - `loop_s`=1 → ARRIVE, counter=1.
- **ARRIVE** (`car_present`=0)
  - `loop_s`=0 → IDLE; the glitch is rejected and not counted.
  - `loop_s`=1 and counter=`DEBOUNCE`-1 → OCCUPIED; `car_pulse`=1 for that one cycle; `car_count` increments.
  - Otherwise the counter increments.
- **OCCUPIED** (`car_present`=1)
  - `loop_s`=0 → DEPART, counter=1.
- **DEPART** (`car_present`=1)
  - `loop_s`=1 → OCCUPIED.
  - `loop_s`=0 and counter=`DEBOUNCE`-1 → HOLD, counter=`HOLD`.
  - Otherwise the counter increments.
- **HOLD** (`car_present`=1)
  - `loop_s`=1 → OCCUPIED with no pulse and no count; the gap is merged into the same occupancy.
  - Otherwise the counter decrements. When counter=1 → IDLE.
- **FAULT** (`car_present`=1, fail-safe so the country road is not starved; `sensor_fault`=1)
  - `loop_s`=0 for `DEBOUNCE` consecutive samples → IDLE.
  - No pulses or counts while in FAULT.
- **car_count**
  - Saturates at 2^`CNT_W`-1.
  - `count_clr` alone sets it to 0.
  - `count_clr` coincident with an increment yields 1.
- **Reset values:** `car_present`=0, `car_pulse`=0, `car_count`=0, `sensor_fault`=0, state=IDLE, synchroniser flops=0, all counters=0.
- **Reset mid-operation:** asserting `clear` in any state immediately zeroes all outputs. There is no pulse on release.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- **Rise latency.** `loop_raw` rises before edge 0 and stays high. `loop_s` is high after edge 1. `car_present` and `car_pulse` are high after edge `DEBOUNCE`+1, i.e. 6 edges for the default.
- **Fall latency.** `loop_raw` falls before edge m. `car_present` falls after edge m+`DEBOUNCE`+`HOLD`+1, i.e. m+13 for the defaults.
- **Glitch rejection.** A high pulse yielding fewer than `DEBOUNCE` high `loop_s` samples never asserts `car_present`. A low gap is bridged if it is shorter than `DEBOUNCE`+`HOLD` samples.
- `car_pulse` is exactly one cycle wide and is never asserted on consecutive cycles.

## Configuration
- **`STUCK_DETECT_EN` defined:** a stuck counter of `$clog2(STUCK_LIMIT+1)` bits runs as follows.
  - It increments on each edge in OCCUPIED with `loop_s`=1 and resets to 0 whenever `loop_s`=0.
  - When it reaches `STUCK_LIMIT`, the FSM enters FAULT on that edge.
- **`STUCK_DETECT_EN` undefined:** the FAULT state and stuck counter are absent, `sensor_fault` is tied to 0, and OCCUPIED persists indefinitely.

## Test plan
- **Reset:** `clear` pulsed while `loop_raw`=1 → all outputs 0 during reset. After release, `car_present` rises 6 edges later with one `car_pulse`; `car_count`=1.
- **Glitches:** `loop_raw` high for 3 cycles, then low → `car_present`, `car_pulse` and `car_count` all remain 0.
- **Single car:** `loop_raw` high for 20 cycles, then low → `car_present` high from edge 5 through 13 edges after the fall; exactly one pulse.
- **Gap merge:** two 20-cycle highs separated by a 6-cycle low → `car_present` stays continuously 1; `car_count`=1. With a 20-cycle gap → it drops, and `car_count`=2.
- **Counter:** 257 qualified cars with `CNT_W`=8 → `car_count`=255. Then `count_clr` coincident with a `car_pulse` → `car_count`=1.
- **Stuck sensor (`STUCK_DETECT_EN`):** `loop_raw` held high for 300 cycles → `sensor_fault`=1 and `car_present`=1. Then `loop_raw` low → both clear after `DEBOUNCE`+2 edges.
